// File: rtl/coproc_axil_regbank.sv
// AXI4-Lite slave register bank for the coprocessor control interface: N registers of
// 32/64 bits, byte strobes, read-only status slots, SLVERR on bad targets, commit pulses.
module coproc_axil_regbank #(
    parameter int                  C_S_AXI_DATA_WIDTH = 32,
    parameter int                  C_S_AXI_ADDR_WIDTH = 6,
    parameter int                  NUM_REGS           = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
    input  logic                                   s00_axi_aclk,
    input  logic                                   s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
    input  logic [2:0]                             s00_axi_awprot,
    input  logic                                   s00_axi_awvalid,
    output logic                                   s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
    input  logic                                   s00_axi_wvalid,
    output logic                                   s00_axi_wready,
    output logic [1:0]                             s00_axi_bresp,
    output logic                                   s00_axi_bvalid,
    input  logic                                   s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
    input  logic [2:0]                             s00_axi_arprot,
    input  logic                                   s00_axi_arvalid,
    output logic                                   s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
    output logic [1:0]                             s00_axi_rresp,
    output logic                                   s00_axi_rvalid,
    input  logic                                   s00_axi_rready,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]                    wr_pulse
);

    localparam int DW   = C_S_AXI_DATA_WIDTH;
    localparam int AW   = C_S_AXI_ADDR_WIDTH;
    localparam int NB   = DW / 8;
    localparam int OFF  = $clog2(NB);
    localparam int IDXW = AW - OFF;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DW-1:0]       regs_r [NUM_REGS];
    logic                aw_held_r, w_held_r;
    logic [IDXW-1:0]     aw_idx_r;
    logic [DW-1:0]       w_data_r;
    logic [NB-1:0]       w_strb_r;
    logic                bvalid_r, rvalid_r;
    logic [1:0]          bresp_r, rresp_r;
    logic [DW-1:0]       rdata_r;
    logic [NUM_REGS-1:0] wr_pulse_r;
    logic                awready_r, wready_r, arready_r;

    logic                aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic [IDXW-1:0]     c_idx_s, r_idx_s;
    logic [DW-1:0]       c_data_s, r_data_s;
    logic [NB-1:0]       c_strb_s;
    logic [NUM_REGS-1:0] wsel_s, rsel_s;
    logic                w_rw_s, r_in_range_s;
    logic                aw_held_n_s, w_held_n_s, bvalid_n_s, rvalid_n_s;
    logic                unused_s;

    assign unused_s = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[OFF-1:0], s00_axi_araddr[OFF-1:0]};

    // Handshakes, commit detection, address decode and next-state of the channel flags.
    always_comb begin
        aw_hs_s  = s00_axi_awvalid & awready_r;
        w_hs_s   = s00_axi_wvalid & wready_r;
        ar_hs_s  = s00_axi_arvalid & arready_r;
        c_idx_s  = aw_held_r ? aw_idx_r : s00_axi_awaddr[AW-1:OFF];
        c_data_s = w_held_r ? w_data_r : s00_axi_wdata;
        c_strb_s = w_held_r ? w_strb_r : s00_axi_wstrb;
        r_idx_s  = s00_axi_araddr[AW-1:OFF];
        commit_s = (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);
        wsel_s   = '0;
        rsel_s   = '0;
        r_data_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wsel_s[i] = (c_idx_s == IDXW'(i));
            rsel_s[i] = (r_idx_s == IDXW'(i));
            // RO slots read the live status input instead of storage.
            r_data_s  = r_data_s | ({DW{rsel_s[i]}} &
                        (RO_MASK[i] ? reg_in[i*DW +: DW] : regs_r[i]));
        end
        w_rw_s       = |(wsel_s & ~RO_MASK);
        r_in_range_s = |rsel_s;
        aw_held_n_s  = commit_s ? 1'b0 : (aw_held_r | aw_hs_s);
        w_held_n_s   = commit_s ? 1'b0 : (w_held_r | w_hs_s);
        bvalid_n_s   = commit_s ? 1'b1 : (bvalid_r & ~s00_axi_bready);
        rvalid_n_s   = ar_hs_s ? 1'b1 : (rvalid_r & ~s00_axi_rready);
    end

    // Channel state, responses, commit pulses and registered ready signals.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            aw_idx_r   <= '0;
            w_data_r   <= '0;
            w_strb_r   <= '0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            rvalid_r   <= 1'b0;
            rdata_r    <= '0;
            rresp_r    <= RESP_OKAY;
            wr_pulse_r <= '0;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            arready_r  <= 1'b0;
        end else begin
            aw_held_r <= aw_held_n_s;
            w_held_r  <= w_held_n_s;
            if (aw_hs_s) begin
                aw_idx_r <= s00_axi_awaddr[AW-1:OFF];
            end
            if (w_hs_s) begin
                w_data_r <= s00_axi_wdata;
                w_strb_r <= s00_axi_wstrb;
            end
            bvalid_r <= bvalid_n_s;
            if (commit_s) begin
                bresp_r <= w_rw_s ? RESP_OKAY : RESP_SLVERR;
            end
            wr_pulse_r <= (commit_s && w_rw_s) ? wsel_s : '0;
            rvalid_r   <= rvalid_n_s;
            if (ar_hs_s) begin
                rdata_r <= r_data_s;
                rresp_r <= r_in_range_s ? RESP_OKAY : RESP_SLVERR;
            end
            // Readies are precomputed so they are already correct in the next cycle.
            awready_r <= ~aw_held_n_s & ~bvalid_n_s;
            wready_r  <= ~w_held_n_s & ~bvalid_n_s;
            arready_r <= ~rvalid_n_s;
        end
    end

    // Register storage: byte-granular update of the committed RW target.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (commit_s && wsel_s[i] && !RO_MASK[i] && c_strb_s[b]) begin
                        regs_r[i][b*8 +: 8] <= c_data_s[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Flattened view of RW contents; RO slots are forced to zero.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DW +: DW] = RO_MASK[i] ? {DW{1'b0}} : regs_r[i];
        end
    end

    assign s00_axi_awready = awready_r;
    assign s00_axi_wready  = wready_r;
    assign s00_axi_arready = arready_r;
    assign s00_axi_bvalid  = bvalid_r;
    assign s00_axi_bresp   = bresp_r;
    assign s00_axi_rvalid  = rvalid_r;
    assign s00_axi_rdata   = rdata_r;
    assign s00_axi_rresp   = rresp_r;
    assign wr_pulse        = wr_pulse_r;

endmodule
